// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART TX stream arbiter.
// Holds the FSM state encoding, the default frame header and pending-buffer sizing.
package tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GEN  = 3'd1,
        HDR  = 3'd2,
        DATA = 3'd3,
        LEN  = 3'd4,
        CSUM = 3'd5
    } arb_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tx_stream_arbiter_if.sv
// Byte-path bundle between the requesters, the arbiter and the UART TX core.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface tx_stream_arbiter_if;
    logic [7:0] gen_data;
    logic       gen_write;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic       adc_strobe;
    logic       cts_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;

    modport slave (
        input  gen_data, gen_write, adc_data, adc_valid, cts_n, tx_ready,
        output adc_strobe, tx_data, tx_start
    );

    modport master (
        output gen_data, gen_write, adc_data, adc_valid, cts_n, tx_ready,
        input  adc_strobe, tx_data, tx_start
    );
endinterface

// File: rtl/gen_byte_fifo.sv
// Small synchronous byte FIFO with sticky overflow; dout is the head (fall-through).
// Write-to-read 1 cycle; a write while full is dropped unless a pop happens the same cycle.
module gen_byte_fifo
    import tx_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign do_rd = rd && !empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign do_wr = wr && (!full || do_rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr && !do_wr) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Shares one UART TX between buffered command bytes and framed ADC packets (A5, payload, len, xor).
// TxStart 1 cycle after an issuable state; stalls on CtsN=1 or TxReady=0, commands only between frames.
module tx_stream_arbiter
    import tx_arb_pkg::*;
#(
    parameter int         FRAME_LEN = 64,
    parameter int         GEN_DEPTH = 4,
    parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_stream_arbiter_if.slave   bus,
    output logic                 gen_overflow,
    output logic [15:0]          frame_count,
    output logic                 busy
);

    localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       guard;
    logic [7:0] cnt;
    logic [7:0] csum;

    logic       issuable;
    logic       issue;
    logic [7:0] issue_dat;
    logic       adc_pop;
    logic       frame_done;

    logic       fifo_rd;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       unused_fifo_full;

    assign unused_fifo_full = fifo_full;

    gen_byte_fifo #(
        .DEPTH (GEN_DEPTH)
    ) u_gen_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr       (bus.gen_write),
        .din      (bus.gen_data),
        .rd       (fifo_rd),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (gen_overflow)
    );

    // The guard covers the cycle before the UART has lowered TxReady.
    assign issuable = bus.tx_ready && !bus.cts_n && !guard;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_dat  = 8'h00;
        adc_pop    = 1'b0;
        fifo_rd    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = GEN;
                end else if (bus.adc_valid) begin
                    state_nxt = HDR;
                end
            end
            GEN: begin
                if (issuable) begin
                    issue     = 1'b1;
                    issue_dat = fifo_dout;
                    fifo_rd   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HDR: begin
                if (issuable) begin
                    issue     = 1'b1;
                    issue_dat = HEADER;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // AdcValid is stale while the previous pop is in flight, so only judge it once the guard drops.
                if (!guard) begin
                    if (!bus.adc_valid) begin
                        state_nxt = LEN;
                    end else if (issuable) begin
                        issue     = 1'b1;
                        issue_dat = bus.adc_data;
                        adc_pop   = 1'b1;
                        if (8'(cnt + 8'd1) == FRAME_LEN_C) begin
                            state_nxt = LEN;
                        end
                    end
                end
            end
            LEN: begin
                if (issuable) begin
                    issue     = 1'b1;
                    issue_dat = cnt;
                    state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (issuable) begin
                    issue      = 1'b1;
                    issue_dat  = csum;
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            guard          <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.adc_strobe <= 1'b0;
            cnt            <= 8'h00;
            csum           <= 8'h00;
            frame_count    <= 16'h0000;
        end else begin
            state          <= state_nxt;
            guard          <= issue;
            bus.tx_start   <= issue;
            bus.adc_strobe <= adc_pop;
            if (issue) begin
                bus.tx_data <= issue_dat;
            end
            if (state == HDR && issue) begin
                cnt  <= 8'h00;
                csum <= 8'h00;
            end
            if (adc_pop) begin
                cnt  <= cnt + 8'd1;
                csum <= csum ^ bus.adc_data;
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed bench: table of ADC frames plus hand sequences for commands, overflow, CTS stall and reset.
module tb_tx_stream_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_stream_arbiter_if bus ();
    logic        gen_overflow;
    logic [15:0] frame_count;
    logic        busy;

    tx_stream_arbiter #(
        .FRAME_LEN (4),
        .GEN_DEPTH (4),
        .HEADER    (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .gen_overflow (gen_overflow),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    // ADC storage FIFO model (first-word fall-through)
    logic [7:0] adc_mem [256];
    logic [7:0] adc_wr = 8'd0;
    logic [7:0] adc_rd = 8'd0;
    assign bus.adc_valid = (adc_rd != adc_wr);
    assign bus.adc_data  = adc_mem[adc_rd];

    // UART model: busy for 10 cycles after each start
    logic uart_rdy = 1'b1;
    int   uart_cnt = 0;
    assign bus.tx_ready = uart_rdy;

    logic [7:0] tx_log [256];
    int n_log = 0;
    int n_strobe = 0;
    int n_viol = 0;
    logic prev_start = 1'b0;

    always @(posedge clk) begin
        if (bus.tx_start) begin
            uart_rdy <= 1'b0;
            uart_cnt <= 10;
            tx_log[n_log[7:0]] <= bus.tx_data;
            n_log <= n_log + 1;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_rdy <= 1'b1;
        end
        if (bus.adc_strobe) begin
            adc_rd   <= adc_rd + 8'd1;
            n_strobe <= n_strobe + 1;
        end
        if (!rst && ((prev_start && bus.tx_start) || (bus.adc_strobe && !bus.tx_start)))
            n_viol <= n_viol + 1;
        prev_start <= bus.tx_start;
    end

    int checks = 0;
    int failures = 0;
    int exp_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_adc(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) adc_mem[8'(adc_wr + 8'(i))] = bytes[(n-1-i)*8 +: 8];
        adc_wr = adc_wr + 8'(n);
    endtask

    task automatic wait_log(input int target, input string name);
        int k = 0;
        while (n_log < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (n_log < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, n_log, target);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        wait_log(target, name);
        while ((busy || !uart_rdy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (30) @(negedge clk);
        check({name, "_count"}, n_log, target);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_seq(input string name, input int base, input logic [127:0] exp, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", name, i), {24'd0, tx_log[8'(base + i)]}, {24'd0, exp[(n-1-i)*8 +: 8]});
    endtask

    task automatic pulse_gen(input logic [7:0] b);
        bus.gen_data  = b;
        bus.gen_write = 1'b1;
        @(negedge clk);
        bus.gen_write = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [63:0] adc;
        int          n_adc;
        logic [127:0] exp;
        int          n_exp;
        int          strobes;
        int          frames;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        int sbase;
        int starts;

        vecs[0] = '{"one_frame", 64'h01020304, 4, 128'hA5_01_02_03_04_04_04, 7, 4, 1};
        vecs[1] = '{"early_term", 64'h102030, 3, 128'hA5_10_20_30_03_00, 6, 3, 1};
        vecs[2] = '{"single", 64'h7F, 1, 128'hA5_7F_01_7F, 4, 1, 1};
        vecs[3] = '{"alt_ff00", 64'hFF00FF00, 4, 128'hA5_FF_00_FF_00_04_00, 7, 4, 1};
        vecs[4] = '{"two_frames", 64'h112233445566, 6, 128'hA5_11_22_33_44_04_44_A5_55_66_02_33, 12, 6, 2};

        bus.gen_data  = 8'h00;
        bus.gen_write = 1'b0;
        bus.cts_n     = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        check("rst_adc_strobe", {31'd0, bus.adc_strobe}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rst_overflow", {31'd0, gen_overflow}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            base  = n_log;
            sbase = n_strobe;
            load_adc(vecs[v].adc, vecs[v].n_adc);
            wait_done(base + vecs[v].n_exp, vecs[v].name);
            compare_seq(vecs[v].name, base, vecs[v].exp, vecs[v].n_exp);
            exp_fc += vecs[v].frames;
            check({vecs[v].name, "_strobes"}, n_strobe - sbase, vecs[v].strobes);
            check({vecs[v].name, "_frames"}, {16'd0, frame_count}, exp_fc);
        end

        // Command byte arriving during the 2nd payload byte waits for the frame end
        base = n_log;
        load_adc(64'h0102030405060708, 8);
        wait_log(base + 3, "midcmd_start");
        pulse_gen(8'h41);
        wait_done(base + 15, "midcmd");
        compare_seq("midcmd", base, 128'hA5_01_02_03_04_04_04_41_A5_05_06_07_08_04_0C, 15);
        exp_fc += 2;
        check("midcmd_frames", {16'd0, frame_count}, exp_fc);

        // CTS stall mid-frame
        base = n_log;
        load_adc(64'h01020304, 4);
        wait_log(base + 3, "cts_start");
        bus.cts_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_start) starts++;
        end
        check("cts_no_starts", starts, 0);
        check("cts_busy", {31'd0, busy}, 32'd1);
        bus.cts_n = 1'b0;
        wait_done(base + 7, "cts");
        compare_seq("cts", base, 128'hA5_01_02_03_04_04_04, 7);
        exp_fc += 1;
        check("cts_frames", {16'd0, frame_count}, exp_fc);

        // Pending-buffer overflow
        base = n_log;
        bus.cts_n = 1'b1;
        for (int i = 0; i < 5; i++) pulse_gen(8'h61 + 8'(i));
        repeat (5) @(negedge clk);
        check("ovf_flag", {31'd0, gen_overflow}, 32'd1);
        check("ovf_held", n_log, base);
        bus.cts_n = 1'b0;
        wait_done(base + 4, "ovf");
        compare_seq("ovf", base, 128'h61_62_63_64, 4);
        check("ovf_sticky", {31'd0, gen_overflow}, 32'd1);

        // Reset mid-frame
        base = n_log;
        load_adc(64'h10203040, 4);
        wait_log(base + 2, "rstmid_start");
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_tx_start", {31'd0, bus.tx_start}, 32'd0);
        check("rstmid_adc_strobe", {31'd0, bus.adc_strobe}, 32'd0);
        check("rstmid_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rstmid_overflow", {31'd0, gen_overflow}, 32'd0);
        check("rstmid_frame_count", {16'd0, frame_count}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_done(base + 8, "rstmid");
        compare_seq("rstmid", base + 2, 128'hA5_20_30_40_03_50, 6);
        check("rstmid_frames", {16'd0, frame_count}, 32'd1);

        check("protocol_violations", n_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
